// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one trial subtraction per clock, MSB first,
// with a start/done handshake. Divide-by-zero short-circuits straight to DONE.

// (n)-bit borrow subtractor: {bout, diff} = a - b.
module nbitsubtract #(
    parameter int unsigned n = 5
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] diff,
    output logic         bout
);
    // Extend by one bit so the top bit of the result is the borrow out.
    assign {bout, diff} = {1'b0, a} - {1'b0, b};
endmodule

module restoring_divider #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);
    localparam int unsigned CW = $clog2(N);
    localparam int unsigned RW = N + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   d_r, d_nxt;
    logic [N-1:0]   q_r, q_nxt;
    logic [RW-1:0]  r_r, r_nxt;
    logic [CW-1:0]  count, count_nxt;
    logic [N-1:0]   quo_nxt, rem_nxt;
    logic           dbz_nxt;

    logic [RW-1:0]  rs;
    logic [RW-1:0]  diff;
    logic           bout;

    // Shifted partial remainder; R[N] is always 0 so dropping it loses nothing.
    assign rs = RW'({r_r, q_r[N-1]});

    nbitsubtract #(.n(RW)) u_sub (
        .a    (rs),
        .b    ({1'b0, d_r}),
        .diff (diff),
        .bout (bout)
    );

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            d_r         <= '0;
            q_r         <= '0;
            r_r         <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_nxt;
            d_r         <= d_nxt;
            q_r         <= q_nxt;
            r_r         <= r_nxt;
            count       <= count_nxt;
            busy        <= (state_nxt == RUN);
            done        <= (state_nxt == DONE);
            quotient    <= quo_nxt;
            remainder   <= rem_nxt;
            div_by_zero <= dbz_nxt;
        end
    end

    // Next-state, iteration step and result capture on entry to DONE.
    always_comb begin
        state_nxt = state;
        d_nxt     = d_r;
        q_nxt     = q_r;
        r_nxt     = r_r;
        count_nxt = count;
        quo_nxt   = quotient;
        rem_nxt   = remainder;
        dbz_nxt   = div_by_zero;

        case (state)
            IDLE: begin
                if (start) begin
                    d_nxt = divisor;
                    q_nxt = dividend;
                    r_nxt = '0;
                    if (divisor == '0) begin
                        state_nxt = DONE;
                        dbz_nxt   = 1'b1;
                        quo_nxt   = '1;
                        rem_nxt   = dividend;
                    end else begin
                        count_nxt = CW'(N - 1);
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (!bout) begin
                    r_nxt = diff;
                    q_nxt = {q_r[N-2:0], 1'b1};
                end else begin
                    r_nxt = rs;
                    q_nxt = {q_r[N-2:0], 1'b0};
                end
                if (count == '0) begin
                    state_nxt = DONE;
                    quo_nxt   = q_nxt;
                    rem_nxt   = r_nxt[N-1:0];
                    dbz_nxt   = 1'b0;
                end else begin
                    count_nxt = count - CW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_restoring_divider.sv
// Directed and exhaustive checks for restoring_divider (N=4), plus a random N=8 instance.
module tb_restoring_divider;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] dividend, divisor;
    logic       busy, done, div_by_zero;
    logic [3:0] quotient, remainder;

    logic       start8;
    logic [7:0] dividend8, divisor8;
    logic       busy8, done8, dbz8;
    logic [7:0] quotient8, remainder8;

    int tests = 0;
    int fails = 0;

    restoring_divider #(.N(4)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    restoring_divider #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .dividend(dividend8), .divisor(divisor8),
        .busy(busy8), .done(done8), .quotient(quotient8), .remainder(remainder8),
        .div_by_zero(dbz8)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one N=4 op and check latency, busy count, results and hold after DONE.
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] eq,
                       input logic [3:0] er, input logic ed, input bit hold, input string tag);
        int cyc;
        int bc;
        int both;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        cyc = 0; bc = 0; both = 0;
        while (!done && cyc < 20) begin
            if (busy) bc++;
            tick();
            cyc++;
        end
        if (busy && done) both++;
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " latency"}, 32'(cyc), ed ? 32'd0 : 32'd4);
        check({tag, " busy_cycles"}, 32'(bc), ed ? 32'd0 : 32'd4);
        check({tag, " busy_with_done"}, 32'(both), 32'd0);
        check({tag, " q"}, 32'(quotient), 32'(eq));
        check({tag, " r"}, 32'(remainder), 32'(er));
        check({tag, " dbz"}, 32'(div_by_zero), 32'(ed));
        tick();
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        check({tag, " q_hold"}, 32'(quotient), 32'(eq));
    endtask

    // N=8 op against a reference computed by the bench.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input string tag);
        int cyc;
        logic [7:0] eq, er;
        logic ed;
        ed = (b == 8'd0);
        eq = ed ? 8'hFF : a / b;
        er = ed ? a : a % b;
        dividend8 = a;
        divisor8  = b;
        start8    = 1'b1;
        tick();
        start8 = 1'b0;
        cyc = 0;
        while (!done8 && cyc < 30) begin
            tick();
            cyc++;
        end
        check({tag, " done"}, 32'(done8), 32'd1);
        check({tag, " latency"}, 32'(cyc), ed ? 32'd0 : 32'd8);
        check({tag, " busy_with_done"}, 32'(busy8 & done8), 32'd0);
        check({tag, " q"}, 32'(quotient8), 32'(eq));
        check({tag, " r"}, 32'(remainder8), 32'(er));
        check({tag, " dbz"}, 32'(dbz8), 32'(ed));
        tick();
    endtask

    initial begin
        int cyc;
        int seen;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        start8 = 1'b0; dividend8 = '0; divisor8 = '0;
        tick();
        tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset q", 32'(quotient), 32'd0);
        check("reset r", 32'(remainder), 32'd0);
        check("reset dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        tick();

        // Directed single operations.
        op4(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1'b0, "13/3");
        op4(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 1'b0, "15/1");
        op4(4'd3, 4'd9, 4'd0, 4'd3, 1'b0, 1'b0, "3/9");
        op4(4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 1'b0, "15/15");
        op4(4'd0, 4'd7, 4'd0, 4'd0, 1'b0, 1'b0, "0/7");
        op4(4'd7, 4'd0, 4'hF, 4'd7, 1'b1, 1'b0, "7/0");
        op4(4'd14, 4'd4, 4'd3, 4'd2, 1'b0, 1'b0, "14/4");

        // Start during RUN and operand changes after acceptance are ignored.
        dividend = 4'd13; divisor = 4'd3; start = 1'b1;
        tick();
        dividend = 4'd2; divisor = 4'd1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
        check("midrun done", 32'(done), 32'd1);
        check("midrun latency", 32'(cyc), 32'd3);
        check("midrun q", 32'(quotient), 32'd4);
        check("midrun r", 32'(remainder), 32'd1);
        // Start during DONE is not queued.
        start = 1'b1; dividend = 4'd6; divisor = 4'd2;
        tick();
        start = 1'b0;
        tick();
        check("done_start busy", 32'(busy), 32'd0);
        check("done_start done", 32'(done), 32'd0);
        check("done_start q", 32'(quotient), 32'd4);
        tick();

        // Reset in the second RUN cycle aborts the op.
        dividend = 4'd13; divisor = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("pre_abort busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort q", 32'(quotient), 32'd0);
        check("abort r", 32'(remainder), 32'd0);
        check("abort dbz", 32'(div_by_zero), 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) seen++;
            tick();
        end
        check("abort quiet", 32'(seen), 32'd0);
        op4(4'd9, 4'd2, 4'd4, 4'd1, 1'b0, 1'b0, "9/2");

        // Exhaustive N=4 with start held high back to back.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [3:0] eq, er;
                eq = (b == 0) ? 4'hF : 4'(a / b);
                er = (b == 0) ? 4'(a) : 4'(a % b);
                op4(4'(a), 4'(b), eq, er, b == 0, 1'b1, "exh");
            end
        end
        start = 1'b0;
        tick();
        tick();

        // N=8 directed and random pairs.
        op8(8'd200, 8'd7, "200/7");
        op8(8'd255, 8'd255, "255/255");
        op8(8'd99, 8'd0, "99/0");
        for (int i = 0; i < 60; i++) begin
            op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "rnd8");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
